uart_cmd_framer: RTL and testbench

//   Command framer between the UART byte receiver/transmitter and the AHB-Lite bus master FSM.

---
 rtl/uart_cmd_pkg.sv | 25 ++
 rtl/uart_cmd_shreg.sv | 47 ++++
 rtl/uart_cmd_framer.sv | 183 ++++++++++++++++++
 tb/tb_uart_cmd_framer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_pkg
// Description : Opcodes and framer state encoding shared by the UART command
//               framer and its host-side test tasks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_cmd_pkg;

    localparam logic [7:0] c_OPC_WR = 8'hA3;
    localparam logic [7:0] c_OPC_RD = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_WDATA    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_SEND     = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_shreg.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_shreg
// Description : 32-bit LSB-first byte shifter with a 2-bit byte index; used
//               both to assemble incoming words and to serialise read data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_shreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        step,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;

    // Each step drops the low byte and enters din at the top, so after four
    // steps the first byte in sits at [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= 32'h0;
            r_idx  <= 2'd0;
        end else if (clr) begin
            r_word <= 32'h0;
            r_idx  <= 2'd0;
        end else if (load) begin
            r_word <= load_data;
            r_idx  <= 2'd0;
        end else if (step) begin
            r_word <= {din, r_word[31:8]};
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign word = r_word;
    assign last = (r_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_framer.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_framer
// Description : Turns host byte frames into single-word bus requests and
//               returns read data to the UART transmitter, LSB first.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] OPC_WR  = c_OPC_WR,
    parameter logic [7:0] OPC_RD  = c_OPC_RD,
    parameter int         TIMEOUT = 65535,
    parameter int         TO_W    = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    output logic        frame_err,
    output logic        overrun
);

    localparam bit              c_TO_EN  = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] c_TO_LIM = c_TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t          r_state;
    logic            r_write;
    logic [31:0]     r_req_addr;
    logic [31:0]     r_req_wdata;
    logic            r_req_valid;
    logic            r_tx_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic [TO_W-1:0] r_to_cnt;

    logic        w_in_frame;
    logic        w_to_fire;
    logic        w_opc_hit;
    logic        w_asm_clr;
    logic        w_asm_step;
    logic        w_asm_last;
    logic [31:0] w_asm_word;
    logic [31:0] w_asm_full;
    logic        w_ser_load;
    logic        w_ser_step;
    logic        w_ser_last;
    logic [31:0] w_ser_word;
    logic        w_unused;

    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_WDATA);
    // Counter holds TIMEOUT-1 on the cycle the TIMEOUT-th idle edge arrives.
    assign w_to_fire  = c_TO_EN && w_in_frame && (r_to_cnt == c_TO_LIM);
    assign w_opc_hit  = rx_valid && ((rx_data == OPC_WR) || (rx_data == OPC_RD));
    assign w_asm_clr  = ((r_state == ST_IDLE) && w_opc_hit) || w_to_fire;
    assign w_asm_step = w_in_frame && rx_valid && !w_to_fire;
    assign w_asm_full = {rx_data, w_asm_word[31:8]};
    assign w_ser_load = (r_state == ST_WAIT_RSP) && rsp_valid && !r_write;
    assign w_ser_step = (r_state == ST_SEND) && tx_ready;
    assign w_unused   = ^{w_asm_word[7:0], w_ser_word[31:8]};

    uart_cmd_shreg u_asm (
        .clk       (HCLK),
        .rst       (HRESET),
        .clr       (w_asm_clr),
        .load      (1'b0),
        .load_data (32'h0),
        .step      (w_asm_step),
        .din       (rx_data),
        .word      (w_asm_word),
        .last      (w_asm_last)
    );

    uart_cmd_shreg u_ser (
        .clk       (HCLK),
        .rst       (HRESET),
        .clr       (1'b0),
        .load      (w_ser_load),
        .load_data (rsp_rdata),
        .step      (w_ser_step),
        .din       (8'h00),
        .word      (w_ser_word),
        .last      (w_ser_last)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_req_addr  <= 32'h0;
            r_req_wdata <= 32'h0;
            r_req_valid <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_frame_err <= 1'b0;
            if (rx_valid && !w_in_frame && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_opc_hit) begin
                        r_write <= (rx_data == OPC_WR);
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_WDATA: begin
                    if (w_to_fire) begin
                        r_frame_err <= 1'b1;
                        r_to_cnt    <= '0;
                        r_state     <= ST_IDLE;
                    end else if (rx_valid) begin
                        r_to_cnt <= '0;
                        if (w_asm_last) begin
                            if (r_state == ST_ADDR) begin
                                r_req_addr <= w_asm_full;
                            end else begin
                                r_req_wdata <= w_asm_full;
                            end
                            if ((r_state == ST_ADDR) && r_write) begin
                                r_state <= ST_WDATA;
                            end else begin
                                r_req_valid <= 1'b1;
                                r_state     <= ST_ISSUE;
                            end
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (r_write) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_state    <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_ready && w_ser_last) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_data   = w_ser_word[7:0];
    assign tx_valid  = r_tx_valid;
    assign req_valid = r_req_valid;
    assign req_write = r_write;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_framer.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_cmd_framer
// Description : Directed self-checking bench for uart_cmd_framer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_framer;
    import uart_cmd_pkg::*;

    logic        HCLK;
    logic        HRESET;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        frame_err;
    logic        overrun;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int acc_cnt  = 0;
    int ferr_cnt = 0;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_write;
    logic [7:0]  tx_q[$];

    uart_cmd_framer #(
        .TIMEOUT (100),
        .TO_W    (16)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Inputs change 2ns after a rising edge; handshakes are observed at the falling edge.
    always @(negedge HCLK) begin
        if (req_valid && req_ready) begin
            acc_cnt   = acc_cnt + 1;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_write = req_write;
        end
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_rsp(input logic [31:0] d);
        rsp_rdata = d;
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        for (int n = 0; n < 40 && acc_cnt < target; n++) tick();
    endtask

    task automatic wait_tx_done(input int nbytes);
        for (int n = 0; n < 60 && (tx_q.size() < nbytes || tx_valid); n++) tick();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) tick();
        chk_cnt++;
        if ({req_valid, tx_valid, frame_err, overrun, req_write} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {req_valid, tx_valid, frame_err, overrun, req_write});
        else pass_cnt++;
        chk_cnt++;
        if ({req_addr, req_wdata, tx_data} !== 72'h0)
            $display("FAIL reset_data: got %h expected 0", {req_addr, req_wdata, tx_data});
        else pass_cnt++;
        chk_cnt++;
        if (dut.r_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE);
        else pass_cnt++;
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int base = acc_cnt;
        tx_q.delete();
        send_byte(8'hA3);
        send_word(32'h0000_0018);
        send_word(32'hA5A8_5501);
        chk_cnt++;
        if (req_valid !== 1'b1) $display("FAIL wr_latency: req_valid got %b expected 1", req_valid);
        else pass_cnt++;
        wait_acc(base + 1);
        chk_cnt++;
        if ({acc_write, acc_addr, acc_wdata} !== {1'b1, 32'h18, 32'hA5A85501})
            $display("FAIL wr_req: got %b %h %h expected 1 00000018 a5a85501", acc_write, acc_addr, acc_wdata);
        else pass_cnt++;
        pulse_rsp(32'h0);
        repeat (4) tick();
        chk_cnt++;
        if (acc_cnt !== base + 1 || tx_q.size() != 0 || tx_valid !== 1'b0)
            $display("FAIL wr_done: accepts %0d tx bytes %0d expected %0d 0", acc_cnt - base, tx_q.size(), 1);
        else pass_cnt++;
    endtask

    task automatic test_read();
        int base = acc_cnt;
        logic [31:0] got;
        tx_q.delete();
        tx_ready = 1'b0;
        send_byte(8'hA5);
        send_word(32'h0000_0014);
        wait_acc(base + 1);
        chk_cnt++;
        if ({acc_write, acc_addr} !== {1'b0, 32'h14})
            $display("FAIL rd_req: got %b %h expected 0 00000014", acc_write, acc_addr);
        else pass_cnt++;
        pulse_rsp(32'hDEAD_BEEF);
        chk_cnt++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hEF})
            $display("FAIL rd_tx_latency: got %b %h expected 1 ef", tx_valid, tx_data);
        else pass_cnt++;
        repeat (5) tick();
        chk_cnt++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hEF} || tx_q.size() != 0)
            $display("FAIL rd_tx_hold: got %b %h sent %0d expected 1 ef 0", tx_valid, tx_data, tx_q.size());
        else pass_cnt++;
        tx_ready = 1'b1;
        wait_tx_done(4);
        got = (tx_q.size() == 4) ? {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} : 32'hx;
        chk_cnt++;
        if (got !== 32'hDEADBEEF || tx_valid !== 1'b0)
            $display("FAIL rd_tx_bytes: got %h (%0d bytes) expected deadbeef", got, tx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int base = acc_cnt;
        logic stable = 1'b1;
        tx_q.delete();
        req_ready = 1'b0;
        send_byte(8'hA5);
        send_word(32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            if (req_valid !== 1'b1 || req_addr !== 32'hFFFFFFFC || req_write !== 1'b0) stable = 1'b0;
            tick();
        end
        chk_cnt++;
        if (stable !== 1'b1 || acc_cnt != base)
            $display("FAIL bp_stall: stable %b accepts %0d expected 1 0", stable, acc_cnt - base);
        else pass_cnt++;
        req_ready = 1'b1;
        wait_acc(base + 1);
        repeat (3) tick();
        chk_cnt++;
        if (acc_cnt != base + 1 || acc_addr !== 32'hFFFFFFFC || req_valid !== 1'b0)
            $display("FAIL bp_accept: accepts %0d addr %h req_valid %b expected 1 fffffffc 0",
                     acc_cnt - base, acc_addr, req_valid);
        else pass_cnt++;
        pulse_rsp(32'h1122_3344);
        wait_tx_done(4);
        chk_cnt++;
        if (tx_q.size() != 4 || tx_q[0] !== 8'h44)
            $display("FAIL bp_rsp: got %0d bytes expected 4 starting 44", tx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int base  = acc_cnt;
        int fbase = ferr_cnt;
        send_byte(8'hA3);
        send_byte(8'h04);
        repeat (99) tick();
        chk_cnt++;
        if (frame_err !== 1'b0 || ferr_cnt != fbase)
            $display("FAIL to_early: frame_err %b pulses %0d expected 0 0", frame_err, ferr_cnt - fbase);
        else pass_cnt++;
        // An opcode arriving on the firing edge must be discarded.
        send_byte(8'hA5);
        chk_cnt++;
        if (frame_err !== 1'b1) $display("FAIL to_pulse: frame_err got %b expected 1", frame_err);
        else pass_cnt++;
        send_word(32'h0000_0020);
        repeat (2) tick();
        chk_cnt++;
        if (frame_err !== 1'b0 || ferr_cnt != fbase + 1 || acc_cnt != base || req_valid !== 1'b0)
            $display("FAIL to_discard: pulses %0d accepts %0d req_valid %b expected 1 0 0",
                     ferr_cnt - fbase, acc_cnt - base, req_valid);
        else pass_cnt++;
        send_byte(8'hA3);
        send_word(32'h0000_0004);
        send_word(32'h1234_5678);
        wait_acc(base + 1);
        chk_cnt++;
        if ({acc_write, acc_addr, acc_wdata} !== {1'b1, 32'h4, 32'h12345678})
            $display("FAIL to_recover: got %b %h %h expected 1 00000004 12345678", acc_write, acc_addr, acc_wdata);
        else pass_cnt++;
        pulse_rsp(32'h0);
        tick();
    endtask

    task automatic test_garbage_overrun();
        int base = acc_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h7E);
        repeat (3) tick();
        chk_cnt++;
        if (acc_cnt != base || req_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL garbage: accepts %0d req_valid %b overrun %b expected 0 0 0", acc_cnt - base, req_valid, overrun);
        else pass_cnt++;
        // Opcode values inside the frame are plain data.
        send_byte(8'hA3);
        send_word(32'h0000_0000);
        send_word(32'hA5A3_A5A3);
        wait_acc(base + 1);
        chk_cnt++;
        if ({acc_write, acc_addr, acc_wdata} !== {1'b1, 32'h0, 32'hA5A3A5A3})
            $display("FAIL opc_as_data: got %b %h %h expected 1 00000000 a5a3a5a3", acc_write, acc_addr, acc_wdata);
        else pass_cnt++;
        send_byte(8'h42);
        chk_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun);
        else pass_cnt++;
        pulse_rsp(32'h0);
        repeat (2) tick();
        chk_cnt++;
        if (overrun !== 1'b1 || dut.r_state !== ST_IDLE || acc_cnt != base + 1)
            $display("FAIL overrun_complete: overrun %b state %0d accepts %0d expected 1 0 1",
                     overrun, dut.r_state, acc_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int base = acc_cnt;
        logic [31:0] got;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h00);
        HRESET = 1'b1;
        tick();
        chk_cnt++;
        if ({req_valid, tx_valid, frame_err, overrun, req_addr, tx_data} !== 44'h0 || dut.r_state !== ST_IDLE)
            $display("FAIL midreset: outputs %h state %0d expected 0 0",
                     {req_valid, tx_valid, frame_err, overrun, req_addr, tx_data}, dut.r_state);
        else pass_cnt++;
        HRESET = 1'b0;
        tick();
        tx_q.delete();
        send_byte(8'hA5);
        send_word(32'h0000_0030);
        wait_acc(base + 1);
        chk_cnt++;
        if ({acc_write, acc_addr} !== {1'b0, 32'h30})
            $display("FAIL midreset_req: got %b %h expected 0 00000030", acc_write, acc_addr);
        else pass_cnt++;
        pulse_rsp(32'h0102_0304);
        wait_tx_done(4);
        got = (tx_q.size() == 4) ? {tx_q[3], tx_q[2], tx_q[1], tx_q[0]} : 32'hx;
        chk_cnt++;
        if (got !== 32'h01020304) $display("FAIL midreset_rsp: got %h expected 01020304", got);
        else pass_cnt++;
    endtask

    initial begin
        HRESET    = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_timeout();
        test_garbage_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
